fifo64x16_ctrl: RTL and testbench
=================================

FIFO64X16_CTRL -- requirements
Module: fifo64x16_ctrl

Interface
REQ-001 Parameter DEPTH, default 64: number of storage words; power of two.
REQ-002 Parameter WIDTH, default 16: data word width in bits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 push  input  1  write request; d_in is captured when push=1 and full=0.
REQ-006 d_in  input  WIDTH  write data.
REQ-007 pop  input  1  read request; accepted when pop=1 and empty=0.
REQ-008 d_out  output  WIDTH  read data; holds its last value when d_valid=0.
REQ-009 d_valid  output  1  one-cycle strobe: d_out carries the word from the pop accepted on the previous cycle.
REQ-010 full  output  1  count==DEPTH.
REQ-011 empty  output  1  count==0.
REQ-012 count  output  7  words stored, 0..64.
REQ-013 overflow  output  1  sticky; set by push while full.
REQ-014 underflow  output  1  sticky; set by pop while empty.

Function
REQ-015 Storage SHALL be the 64x16 dual-port RAM, with one write port and one read port, driven through wr/waddr/d_in and rd/raddr/d_out.
REQ-016 Write and read pointers SHALL be 7 bits each: bits [5:0] address the RAM, bit 6 is the wrap bit.
REQ-017 An accepted push SHALL write d_in at wptr[5:0] in that cycle and increment wptr modulo 128.
REQ-018 An accepted pop SHALL issue rd at rptr[5:0] and increment rptr modulo 128; d_out and d_valid=1 SHALL follow one cycle later (latency 1).
REQ-019 full SHALL equal (wptr[6]!=rptr[6]) && (wptr[5:0]==rptr[5:0]); empty SHALL equal wptr==rptr; both are registered, with no combinational path from push or pop.
REQ-020 count SHALL change by +1 (push only), by -1 (pop only), or by 0 (both accepted, or neither).
REQ-021 Push while full SHALL be ignored: no write, no pointer change, overflow set.
REQ-022 Pop while empty SHALL be ignored: no read, d_valid=0 next cycle, underflow set.
REQ-023 Push and pop together while empty: the push is accepted, the pop is rejected, underflow is set, and count becomes 1.
REQ-024 Push and pop together while full: the pop is accepted, the push is rejected, overflow is set, and count becomes 63; this avoids a read/write to the same address.
REQ-025 Push and pop together otherwise: both are accepted and count is unchanged.
REQ-026 Pointer wrap from address 63 to 0 SHALL be seamless; data order is strictly FIFO.
REQ-027 overflow and underflow SHALL clear only on rst.

Reset
REQ-028 rst=1 SHALL set wptr=0, rptr=0, count=0, empty=1, full=0, d_valid=0, d_out=0, overflow=0, underflow=0.
REQ-029 Reset SHALL take priority over push and pop in the same cycle.
REQ-030 Reset mid-operation SHALL discard all stored data logically; RAM contents need not be cleared.
REQ-031 A pop in the cycle before rst SHALL NOT produce d_valid=1 during or after the reset cycle.

Structure
REQ-032 A shared package SHALL hold DEPTH, WIDTH, and the pointer width (PTR_W=7, ADDR_W=6).
REQ-033 A single sub-module SHALL be instantiated: the existing 64x16 dual-port RAM; pointer, flag and count logic live in fifo64x16_ctrl.

Verification
REQ-034 Reset, then push 16'hadca, 16'h5767, 16'ha7cd; pop x3 -> d_out adca, 5767, a7cd on consecutive cycles, each with d_valid=1; final empty=1, count=0.
REQ-035 Push 64 words 16'h0000..16'h003f -> full=1 and count=64 after the 64th; a 65th push (16'hffff) -> overflow=1, count stays 64; pop 64 -> 0000..003f in order, no ffff.
REQ-036 Fill 40, pop 40, push 40 more, pop 40 -> pointers wrap past 63; data 0..39 is returned intact and in order.
REQ-037 With count=0, push+pop of 16'h1234 together -> count=1, underflow=1, no d_valid; next pop -> 1234.
REQ-038 With full, push+pop together -> count=63, overflow=1, oldest word returned; with count=10, push+pop together -> count stays 10.
REQ-039 With count=5 and pop asserted, apply rst for 1 cycle -> count=0, empty=1, d_valid=0 in the following cycle, and flags cleared.

Source files
------------

// File: rtl/fifo64x16_pkg.sv
// Shared sizing constants for the 64x16 FIFO controller and its RAM.
package fifo64x16_pkg;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned PTR_W  = 7;

endpackage

// File: rtl/fifo64x16_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module fifo64x16_ram
  import fifo64x16_pkg::*;
#(
  parameter int unsigned Depth = fifo64x16_pkg::DEPTH,
  parameter int unsigned Width = fifo64x16_pkg::WIDTH,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] d_in,
  input  logic             rd,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] d_out
);

  logic [Width-1:0] mem [Depth];

  // Storage array is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[waddr] <= d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= '0;
    end else if (rd) begin
      d_out <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo64x16_ctrl.sv
// Synchronous FIFO controller: wrap-bit pointers, registered flags, sticky over/underflow.
module fifo64x16_ctrl
  import fifo64x16_pkg::*;
#(
  parameter int unsigned DEPTH = fifo64x16_pkg::DEPTH,
  parameter int unsigned WIDTH = fifo64x16_pkg::WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       d_in,
  input  logic                   pop,
  output logic [WIDTH-1:0]       d_out,
  output logic                   d_valid,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q;
  logic          full_q, empty_q;
  logic          d_valid_q;
  logic          overflow_q, underflow_q;
  logic          push_ok, pop_ok;

  // Flags are registered, so acceptance never depends combinationally on the other request.
  always_comb begin
    push_ok = push & ~full_q;
    pop_ok  = pop & ~empty_q;
    wptr_d  = wptr_q + PW'(push_ok);
    rptr_d  = rptr_q + PW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      d_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= wptr_d - rptr_d;
      full_q      <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
      empty_q     <= (wptr_d == rptr_d);
      d_valid_q   <= pop_ok;
      overflow_q  <= overflow_q | (push & full_q);
      underflow_q <= underflow_q | (pop & empty_q);
    end
  end

  fifo64x16_ram #(
    .Depth (DEPTH),
    .Width (WIDTH),
    .AddrW (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .wr    (push_ok & ~rst),
    .waddr (wptr_q[AW-1:0]),
    .d_in  (d_in),
    .rd    (pop_ok & ~rst),
    .raddr (rptr_q[AW-1:0]),
    .d_out (d_out)
  );

  // Masking with rst keeps a strobe from a pop just before reset out of the reset cycle.
  assign d_valid   = d_valid_q & ~rst;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo64x16_ctrl.sv
// Directed self-checking bench for fifo64x16_ctrl.
module tb_fifo64x16_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0;
  logic [15:0] d_in = '0;
  logic        pop = 1'b0;
  logic [15:0] d_out;
  logic        d_valid;
  logic        full;
  logic        empty;
  logic [6:0]  count;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  fifo64x16_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .d_in      (d_in),
    .pop       (pop),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; push = 1'b0; pop = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w);
    push = 1'b1; d_in = w;
    tick();
    push = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; push = 1'b1; pop = 1'b1; d_in = 16'hdead;
    tick();
    rst = 1'b0; push = 1'b0; pop = 1'b0;
    checks++;
    if ({count, empty, full, d_valid, overflow, underflow} !== {7'd0, 5'b10000}) begin
      errors++;
      $display("FAIL reset_state got cnt=%0d e=%b f=%b v=%b ov=%b un=%b want cnt=0 e=1 others 0",
               count, empty, full, d_valid, overflow, underflow);
    end
    checks++;
    if (d_out !== 16'h0000) begin
      errors++; $display("FAIL reset_dout got %h want 0000", d_out);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp [3];
    exp[0] = 16'hadca; exp[1] = 16'h5767; exp[2] = 16'ha7cd;
    do_reset();
    for (int i = 0; i < 3; i++) push_word(exp[i]);
    checks++;
    if (count !== 7'd3 || empty !== 1'b0) begin
      errors++; $display("FAIL basic_count got %0d e=%b want 3 e=0", count, empty);
    end
    pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (d_valid !== 1'b1 || d_out !== exp[i]) begin
        errors++;
        $display("FAIL basic_pop%0d got v=%b d=%h want v=1 d=%h", i, d_valid, d_out, exp[i]);
      end
    end
    pop = 1'b0;
    tick();
    checks++;
    if (d_valid !== 1'b0 || d_out !== 16'ha7cd || empty !== 1'b1 || count !== 7'd0) begin
      errors++;
      $display("FAIL basic_end got v=%b d=%h e=%b cnt=%0d want v=0 d=a7cd e=1 cnt=0",
               d_valid, d_out, empty, count);
    end
  endtask

  task automatic test_full();
    int bad;
    do_reset();
    for (int i = 0; i < 63; i++) push_word(16'(i));
    checks++;
    if (full !== 1'b0 || count !== 7'd63) begin
      errors++; $display("FAIL full_at63 got f=%b cnt=%0d want f=0 cnt=63", full, count);
    end
    push_word(16'h003f);
    checks++;
    if (full !== 1'b1 || count !== 7'd64 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_at64 got f=%b cnt=%0d ov=%b want f=1 cnt=64 ov=0", full, count, overflow);
    end
    push_word(16'hffff);
    checks++;
    if (overflow !== 1'b1 || count !== 7'd64 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow got ov=%b cnt=%0d f=%b want ov=1 cnt=64 f=1", overflow, count, full);
    end
    bad = 0;
    pop = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (d_valid !== 1'b1 || d_out !== 16'(i)) bad++;
    end
    pop = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL full_drain got %0d bad words want 0", bad);
    end
    checks++;
    if (empty !== 1'b1 || count !== 7'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_after got e=%b cnt=%0d ov=%b want e=1 cnt=0 ov=1", empty, count, overflow);
    end
  endtask

  task automatic test_wrap();
    int bad;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 40; i++) push_word(16'(i));
      bad = 0;
      pop = 1'b1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (d_valid !== 1'b1 || d_out !== 16'(i)) bad++;
      end
      pop = 1'b0;
      checks++;
      if (bad != 0 || empty !== 1'b1) begin
        errors++; $display("FAIL wrap_pass%0d got bad=%0d e=%b want bad=0 e=1", pass, bad, empty);
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if (underflow !== 1'b1 || d_valid !== 1'b0 || count !== 7'd0) begin
      errors++;
      $display("FAIL underflow got un=%b v=%b cnt=%0d want un=1 v=0 cnt=0", underflow, d_valid, count);
    end
    do_reset();
    push = 1'b1; pop = 1'b1; d_in = 16'h1234;
    tick();
    push = 1'b0; pop = 1'b0;
    checks++;
    if (count !== 7'd1 || underflow !== 1'b1 || d_valid !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_pushpop got cnt=%0d un=%b v=%b e=%b want cnt=1 un=1 v=0 e=0",
               count, underflow, d_valid, empty);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if (d_valid !== 1'b1 || d_out !== 16'h1234) begin
      errors++; $display("FAIL empty_pushpop_read got v=%b d=%h want v=1 d=1234", d_valid, d_out);
    end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    for (int i = 0; i < 64; i++) push_word(16'h0100 + 16'(i));
    push = 1'b1; pop = 1'b1; d_in = 16'hbeef;
    tick();
    push = 1'b0; pop = 1'b0;
    checks++;
    if (count !== 7'd63 || overflow !== 1'b1 || d_valid !== 1'b1 || d_out !== 16'h0100 ||
        full !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop got cnt=%0d ov=%b v=%b d=%h f=%b want cnt=63 ov=1 v=1 d=0100 f=0",
               count, overflow, d_valid, d_out, full);
    end
    do_reset();
    for (int i = 0; i < 10; i++) push_word(16'h0200 + 16'(i));
    push = 1'b1; pop = 1'b1; d_in = 16'h0abc;
    tick();
    push = 1'b0; pop = 1'b0;
    checks++;
    if (count !== 7'd10 || d_valid !== 1'b1 || d_out !== 16'h0200 || overflow !== 1'b0 ||
        underflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_pushpop got cnt=%0d v=%b d=%h ov=%b un=%b want cnt=10 v=1 d=0200 ov=0 un=0",
               count, d_valid, d_out, overflow, underflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) push_word(16'h0300 + 16'(i));
    pop = 1'b1;
    tick();
    pop = 1'b1; rst = 1'b1;
    #1;
    checks++;
    if (d_valid !== 1'b0) begin
      errors++; $display("FAIL reset_cycle_valid got %b want 0", d_valid);
    end
    tick();
    rst = 1'b0; pop = 1'b0;
    checks++;
    if ({count, empty, full, d_valid, overflow, underflow} !== {7'd0, 5'b10000}) begin
      errors++;
      $display("FAIL reset_mid got cnt=%0d e=%b f=%b v=%b ov=%b un=%b want cnt=0 e=1 others 0",
               count, empty, full, d_valid, overflow, underflow);
    end
    tick();
    checks++;
    if (d_valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL reset_mid_after got v=%b e=%b want v=0 e=1", d_valid, empty);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_underflow();
    test_full_pushpop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
